hex_scan_ctrl: RTL

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - multiplexed hex display scanner with tear-free double-buffered load
module hex_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    blank_lz,
    output logic [3:0]              dec_nibble,
    input  logic [6:0]              dec_display,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg_out,
    output logic                    dp_out
);

    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    frame_boundary;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    blanked;

    assign load_ready     = !pend_valid_q && !rst;
    assign frame_boundary = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    assign dec_nibble     = cur_nib;
    assign digit_sel      = digit_sel_q;
    assign seg_out        = seg_q;
    assign dp_out         = dp_q;

    // lz_mask[i]: digits i..top carry neither a nonzero nibble nor a decimal point
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            lz_mask[i] = run;
            if (idx_q == IW'(i)) begin
                cur_nib = act_data_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
            end
        end
    end

    assign blanked = blank_lz && (idx_q != '0) && lz_mask[idx_q];

    always_comb begin
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (frame_boundary && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end else if (load_valid && load_ready) begin
            pend_data_d  = load_data;
            pend_dp_d    = load_dp;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state; idx never changes on entry to SHOW,
    // so the decoder result returned this cycle belongs to the digit about to light.
    always_comb begin
        digit_sel_d = '1;
        seg_d       = 7'h7F;
        dp_d        = 1'b1;
        if (state_d == ST_SHOW && !blanked) begin
            digit_sel_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d       = dec_display;
            dp_d        = !cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            digit_sel_q  <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

endmodule
